collision_response: RTL and testbench

- Consumes the 3-bit enemy-collision direction code from the collision detector and updates the player position accordingly.
- Applies a multi-frame knockback away from the enemy, then a timed invulnerability window, and tracks remaining lives and game over.
- Sits between the player movement logic, which supplies the requested position, and the sprite renderer, which uses the registered position.
- Position packing: [19:10] = x, [9:0] = y.

---
 rtl/collision_response.sv | 205 ++++++++++++++++++++
 tb/tb_collision_response.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/collision_response.sv
// Player collision response: knockback, invulnerability window, lives and game over.
// Optional macro SPRITE_BLINK_EN builds a frame counter that blinks the sprite while invulnerable.
module collision_response #(
    parameter int STEP          = 4,
    parameter int KB_FRAMES     = 4,
    parameter int INVULN_FRAMES = 60,
    parameter int LIVES_INIT    = 3,
    parameter int X_MAX         = 623,
    parameter int Y_MAX         = 459,
    parameter int X_START       = 320,
    parameter int Y_START       = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic [2:0]  enemy_collide,
    input  logic [19:0] pos_in,
    output logic [19:0] pos_out,
    output logic [1:0]  lives,
    output logic        hit,
    output logic        knockback,
    output logic        invuln,
    output logic        game_over,
    output logic        visible
);

    typedef enum logic [1:0] {IDLE, KNOCK, INVULN, DEAD} state_t;

    localparam int KB_W  = $clog2(KB_FRAMES) + 1;
    localparam int INV_W = $clog2(INVULN_FRAMES) + 1;
    localparam logic [KB_W-1:0]  KB_LOAD   = KB_W'(KB_FRAMES - 1);
    localparam logic [INV_W-1:0] INV_LOAD  = INV_W'(INVULN_FRAMES - 1);
    localparam logic [10:0]      STEP_W    = 11'(STEP);
    localparam logic [10:0]      X_MAX_W   = 11'(X_MAX);
    localparam logic [10:0]      Y_MAX_W   = 11'(Y_MAX);
    localparam logic [19:0]      POS_RESET = {10'(X_START), 10'(Y_START)};

    // Push direction: 0 = +y, 1 = -y, 2 = +x, 3 = -x (code minus one)
    state_t             state_r, state_s;
    logic [19:0]        pos_r, pos_s;
    logic [1:0]         lives_r, lives_s;
    logic               hit_r, hit_s;
    logic [KB_W-1:0]    kb_cnt_r, kb_cnt_s;
    logic [INV_W-1:0]   inv_cnt_r, inv_cnt_s;
    logic [1:0]         dir_r, dir_s;
    logic               knock_r, invuln_r, over_r;
    logic               valid_s;

    // One axis step in 11 bits, saturating to [0, max_v] so nothing wraps.
    function automatic logic [9:0] step_axis(input logic [9:0] v, input logic neg,
                                             input logic [10:0] max_v);
        logic [10:0] w;
        if (neg) begin
            w = ({1'b0, v} >= STEP_W) ? ({1'b0, v} - STEP_W) : 11'd0;
        end else begin
            w = {1'b0, v} + STEP_W;
        end
        if (w > max_v) begin
            w = max_v;
        end else begin
            w = w;
        end
        return w[9:0];
    endfunction

    function automatic logic [19:0] push(input logic [19:0] p, input logic [1:0] dir);
        logic [19:0] r;
        r = p;
        case (dir)
            2'd0:    r[9:0]   = step_axis(p[9:0],   1'b0, Y_MAX_W);
            2'd1:    r[9:0]   = step_axis(p[9:0],   1'b1, Y_MAX_W);
            2'd2:    r[19:10] = step_axis(p[19:10], 1'b0, X_MAX_W);
            2'd3:    r[19:10] = step_axis(p[19:10], 1'b1, X_MAX_W);
            default: r = p;
        endcase
        return r;
    endfunction

    assign valid_s = (enemy_collide >= 3'd1) && (enemy_collide <= 3'd4);

    // Next-state and next-output logic; everything holds unless frame_tick is high.
    always_comb begin
        state_s   = state_r;
        pos_s     = pos_r;
        lives_s   = lives_r;
        hit_s     = 1'b0;
        kb_cnt_s  = kb_cnt_r;
        inv_cnt_s = inv_cnt_r;
        dir_s     = dir_r;
        if (frame_tick) begin
            case (state_r)
                IDLE: begin
                    pos_s = pos_in;
                    if (valid_s) begin
                        dir_s    = 2'(enemy_collide - 3'd1);
                        lives_s  = lives_r - 2'd1;
                        hit_s    = 1'b1;
                        kb_cnt_s = KB_LOAD;
                        state_s  = KNOCK;
                    end else begin
                        state_s = IDLE;
                    end
                end
                KNOCK: begin
                    pos_s = push(pos_r, dir_r);
                    if (kb_cnt_r == {KB_W{1'b0}}) begin
                        if (lives_r == 2'd0) begin
                            state_s = DEAD;
                        end else begin
                            state_s   = INVULN;
                            inv_cnt_s = INV_LOAD;
                        end
                    end else begin
                        kb_cnt_s = kb_cnt_r - {{(KB_W-1){1'b0}}, 1'b1};
                    end
                end
                INVULN: begin
                    pos_s = pos_in;
                    if (inv_cnt_r == {INV_W{1'b0}}) begin
                        state_s = IDLE;
                    end else begin
                        inv_cnt_s = inv_cnt_r - {{(INV_W-1){1'b0}}, 1'b1};
                    end
                end
                DEAD: begin
                    state_s = DEAD;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers; status flags are decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pos_r     <= POS_RESET;
            lives_r   <= 2'(LIVES_INIT);
            hit_r     <= 1'b0;
            kb_cnt_r  <= {KB_W{1'b0}};
            inv_cnt_r <= {INV_W{1'b0}};
            dir_r     <= 2'd0;
            knock_r   <= 1'b0;
            invuln_r  <= 1'b0;
            over_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            pos_r     <= pos_s;
            lives_r   <= lives_s;
            hit_r     <= hit_s;
            kb_cnt_r  <= kb_cnt_s;
            inv_cnt_r <= inv_cnt_s;
            dir_r     <= dir_s;
            knock_r   <= (state_s == KNOCK);
            invuln_r  <= (state_s == KNOCK) || (state_s == INVULN);
            over_r    <= (state_s == DEAD);
        end
    end

`ifdef SPRITE_BLINK_EN
    logic [2:0] blink_r, blink_s;
    logic       visible_r;

    // Blink counter restarts on the hit that enters KNOCK, otherwise counts frames.
    always_comb begin
        blink_s = blink_r;
        if (frame_tick) begin
            if ((state_r == IDLE) && valid_s) begin
                blink_s = 3'd0;
            end else begin
                blink_s = blink_r + 3'd1;
            end
        end else begin
            blink_s = blink_r;
        end
    end

    // Visible register: 4 frames on / 4 off while invulnerable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_r   <= 3'd0;
            visible_r <= 1'b1;
        end else begin
            blink_r   <= blink_s;
            visible_r <= ((state_s == KNOCK) || (state_s == INVULN)) ? ~blink_s[2] : 1'b1;
        end
    end

    assign visible = visible_r;
`else
    assign visible = 1'b1;
`endif

    assign pos_out   = pos_r;
    assign lives     = lives_r;
    assign hit       = hit_r;
    assign knockback = knock_r;
    assign invuln    = invuln_r;
    assign game_over = over_r;

endmodule

// File: tb/tb_collision_response.sv
// Randomized self-checking bench for collision_response against a frame-level reference model.
module tb_collision_response;

    localparam int STEP = 4, KB_FRAMES = 4, INVULN_FRAMES = 60;
    localparam int X_MAX = 623, Y_MAX = 459;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [2:0]  enemy_collide = 3'd0;
    logic [19:0] pos_in = 20'd0;
    logic [19:0] pos_out;
    logic [1:0]  lives;
    logic        hit, knockback, invuln, game_over, visible;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 knockback, 2 invulnerable, 3 dead
    int m_phase, m_left, m_x, m_y, m_lives, m_dx, m_dy;
    bit m_hit;

    collision_response dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .enemy_collide(enemy_collide), .pos_in(pos_in), .pos_out(pos_out),
        .lives(lives), .hit(hit), .knockback(knockback), .invuln(invuln),
        .game_over(game_over), .visible(visible)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".x"},         32'(pos_out[19:10]), 32'(m_x));
        check_eq({tag, ".y"},         32'(pos_out[9:0]),   32'(m_y));
        check_eq({tag, ".lives"},     32'(lives),          32'(m_lives));
        check_eq({tag, ".hit"},       32'(hit),            32'(m_hit));
        check_eq({tag, ".knockback"}, 32'(knockback),      32'(m_phase == 1));
        check_eq({tag, ".invuln"},    32'(invuln),         32'(m_phase == 1 || m_phase == 2));
        check_eq({tag, ".game_over"}, 32'(game_over),      32'(m_phase == 3));
        check_eq({tag, ".visible"},   32'(visible),        32'd1);
    endtask

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_x = 320; m_y = 240;
        m_lives = 3; m_dx = 0; m_dy = 0; m_hit = 0;
    endtask

    task automatic model_tick(input int code, input int px, input int py);
        m_hit = 0;
        case (m_phase)
            0: begin
                m_x = px; m_y = py;
                if (code >= 1 && code <= 4) begin
                    m_lives = m_lives - 1;
                    m_hit = 1;
                    m_dx = (code == 3) ? STEP : (code == 4) ? -STEP : 0;
                    m_dy = (code == 1) ? STEP : (code == 2) ? -STEP : 0;
                    m_phase = 1;
                    m_left = KB_FRAMES;
                end
            end
            1: begin
                m_x = clamp(m_x + m_dx, X_MAX);
                m_y = clamp(m_y + m_dy, Y_MAX);
                m_left--;
                if (m_left == 0) begin
                    if (m_lives == 0) m_phase = 3;
                    else begin m_phase = 2; m_left = INVULN_FRAMES; end
                end
            end
            2: begin
                m_x = px; m_y = py;
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
            default: ;
        endcase
    endtask

    // Called at posedge+1; applies one frame tick, then a quiet clock with a junk code.
    task automatic do_tick(input int code, input int px, input int py);
        enemy_collide = 3'(code);
        pos_in = {10'(px), 10'(py)};
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        enemy_collide = 3'($urandom_range(0, 7));
        pos_in = {10'($urandom_range(0, X_MAX)), 10'($urandom_range(0, Y_MAX))};
        model_tick(code, px, py);
        check_all("tick");
        @(posedge clk); #1;
        m_hit = 0;
        check_all("gap");
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        frame_tick = 1'b1;
        enemy_collide = 3'd1;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame_tick = 1'b0;
        enemy_collide = 3'd0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        int code;
        model_reset();
        @(posedge clk); #1;
        do_reset(2);

        // Basic hit and four-frame knockback to the left
        do_tick(4, 100, 200);
        check_eq("hit_lives", 32'(lives), 32'd2);
        repeat (4) do_tick(0, 500, 400);
        check_eq("kb_x", 32'(pos_out[19:10]), 32'd84);
        check_eq("kb_y", 32'(pos_out[9:0]), 32'd200);

        // Invulnerability: 60 frames ignore hits, the next one lands
        repeat (60) do_tick(2, 300, 300);
        check_eq("inv_lives", 32'(lives), 32'd2);
        do_tick(2, 300, 300);
        check_eq("post_inv_hit_lives", 32'(lives), 32'd1);

        // Clamps on every edge
        do_reset(1);
        do_tick(4, 2, 50);
        repeat (4) do_tick(0, 10, 10);
        check_eq("clamp_x0", 32'(pos_out[19:10]), 32'd0);
        do_reset(1);
        do_tick(3, 621, 457);
        repeat (4) do_tick(0, 10, 10);
        check_eq("clamp_xmax", 32'(pos_out[19:10]), 32'd623);
        do_reset(1);
        do_tick(1, 300, 457);
        repeat (4) do_tick(0, 10, 10);
        check_eq("clamp_ymax", 32'(pos_out[9:0]), 32'd459);
        do_reset(1);
        do_tick(2, 300, 1);
        repeat (4) do_tick(0, 10, 10);
        check_eq("clamp_y0", 32'(pos_out[9:0]), 32'd0);

        // Ignored codes and inputs without frame_tick
        do_reset(1);
        for (int c = 5; c < 8; c++) do_tick(c, 50 + c, 60 + c);
        enemy_collide = 3'd1;
        pos_in = {10'd7, 10'd9};
        repeat (3) @(posedge clk);
        #1;
        check_all("no_tick");

        // Game over after three hits, then frozen until reset
        do_reset(1);
        for (int h = 0; h < 3; h++) begin
            do_tick(3, 200, 100);
            repeat (KB_FRAMES + INVULN_FRAMES) do_tick(0, 210, 110);
        end
        check_eq("dead_flag", 32'(game_over), 32'd1);
        check_eq("dead_lives", 32'(lives), 32'd0);
        for (int i = 0; i < 5; i++) do_tick(i, 400 + i, 50 + i);
        do_reset(1);

        // Randomized run; reset whenever the model has been dead for a while
        for (int i = 0; i < 600; i++) begin
            code = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
            case ($urandom_range(0, 3))
                0:       do_tick(code, $urandom_range(0, 5), $urandom_range(Y_MAX - 5, Y_MAX));
                1:       do_tick(code, $urandom_range(X_MAX - 5, X_MAX), $urandom_range(0, 5));
                default: do_tick(code, $urandom_range(0, X_MAX), $urandom_range(0, Y_MAX));
            endcase
            if (m_phase == 3 && $urandom_range(0, 7) == 0) do_reset(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
